// File: rtl/electrode_seq_pkg.sv
// Shared state encoding and default sizing for the electrode config sequencer.
// Pure declarations; no logic, no latency, no flow control.
package electrode_seq_pkg;

  localparam int N_ELECTRODES_DEF = 129;
  localparam int CFG_DEPTH_DEF    = 8;
  localparam int CFG_AW_DEF       = 3;
  localparam int SETTLE_CYC_DEF   = 64;
  localparam int TIMEOUT_CYC_DEF  = 160;
  localparam int CNT_W            = 16;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    KICK,
    SR_WAIT,
    LATCH,
    SETTLE,
    ACQ,
    NEXT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/electrode_cfg_bank.sv
// Config register file: one synchronous write port, one combinational read port.
// Write lands on the next rising edge; no backpressure, caller gates the write enable.
module electrode_cfg_bank
  import electrode_seq_pkg::*;
#(
  parameter int WIDTH = N_ELECTRODES_DEF,
  parameter int DEPTH = CFG_DEPTH_DEF,
  parameter int AW    = CFG_AW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/electrode_cfg_sequencer.sv
// Steps stored electrode configs through serializer kick, latch, settle and readout handshake.
// Per config LOAD->acq_start is 3 + T_sr + SETTLE_CYC cycles; waits indefinitely on acq_done, abort always wins.
module electrode_cfg_sequencer
  import electrode_seq_pkg::*;
#(
  parameter int N_ELECTRODES = N_ELECTRODES_DEF,
  parameter int CFG_DEPTH    = CFG_DEPTH_DEF,
  parameter int CFG_AW       = CFG_AW_DEF,
  parameter int SETTLE_CYC   = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cfg_wr_en,
  input  logic [CFG_AW-1:0]       cfg_wr_addr,
  input  logic [N_ELECTRODES-1:0] cfg_wr_data,
  input  logic [CFG_AW:0]         num_cfg,
  input  logic                    continuous,
  input  logic                    start,
  input  logic                    abort,
  output logic [N_ELECTRODES-1:0] electr_config_out,
  output logic                    enable_desp,
  input  logic                    sr_finish,
  output logic                    latch_out,
  output logic                    acq_start,
  input  logic                    acq_done,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [CFG_AW-1:0]       cur_idx
);

  localparam logic [CFG_AW:0]    DEPTH_V  = (CFG_AW+1)'(CFG_DEPTH);
  localparam logic [CFG_AW:0]    NUM_ONE  = (CFG_AW+1)'(1);
  localparam logic [CFG_AW-1:0]  IDX_ONE  = CFG_AW'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   SET_LAST = CNT_W'(SETTLE_CYC - 1);

  seq_state_t              state, state_nxt;
  logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
  logic [CFG_AW-1:0]       idx_nxt;
  logic [CFG_AW:0]         num_q, num_nxt;
  logic                    cont_q, cont_nxt;
  logic                    terr_nxt;
  logic [N_ELECTRODES-1:0] cfg_nxt;
  logic [N_ELECTRODES-1:0] bank_rd;
  logic                    num_ok;
  logic                    last_cfg;

  electrode_cfg_bank #(
    .WIDTH (N_ELECTRODES),
    .DEPTH (CFG_DEPTH),
    .AW    (CFG_AW)
  ) u_bank (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (cfg_wr_en && (state == IDLE)),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (cur_idx),
    .rd_data (bank_rd)
  );

  assign num_ok   = (num_cfg != '0) && (num_cfg <= DEPTH_V);
  assign last_cfg = ({1'b0, cur_idx} == (num_q - NUM_ONE));
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      cur_idx           <= '0;
      num_q             <= '0;
      cont_q            <= 1'b0;
      timeout_err       <= 1'b0;
      electr_config_out <= '0;
    end else begin
      state             <= state_nxt;
      wait_cnt          <= wait_cnt_nxt;
      cur_idx           <= idx_nxt;
      num_q             <= num_nxt;
      cont_q            <= cont_nxt;
      timeout_err       <= terr_nxt;
      electr_config_out <= cfg_nxt;
    end
  end

  // Strobes come only from the case body, so an abort cycle emits none of them.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    idx_nxt      = cur_idx;
    num_nxt      = num_q;
    cont_nxt     = cont_q;
    terr_nxt     = timeout_err;
    cfg_nxt      = electr_config_out;
    enable_desp  = 1'b0;
    latch_out    = 1'b0;
    acq_start    = 1'b0;
    done         = 1'b0;

    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && num_ok) begin
            state_nxt = LOAD;
            num_nxt   = num_cfg;
            cont_nxt  = continuous;
            idx_nxt   = '0;
            terr_nxt  = 1'b0;
          end
        end
        LOAD: begin
          cfg_nxt   = bank_rd;
          state_nxt = KICK;
        end
        KICK: begin
          enable_desp  = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = SR_WAIT;
        end
        SR_WAIT: begin
          // A finish arriving on the final allowed cycle still counts.
          if (sr_finish) begin
            state_nxt = LATCH;
          end else if (wait_cnt == TO_LAST) begin
            terr_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + CNT_ONE;
          end
        end
        LATCH: begin
          latch_out    = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = SETTLE;
        end
        SETTLE: begin
          if (wait_cnt == SET_LAST) begin
            state_nxt = ACQ;
          end else begin
            wait_cnt_nxt = wait_cnt + CNT_ONE;
          end
        end
        ACQ: begin
          acq_start = 1'b1;
          if (acq_done) state_nxt = NEXT;
        end
        NEXT: begin
          if (last_cfg) begin
            if (cont_q) begin
              idx_nxt   = '0;
              state_nxt = LOAD;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            idx_nxt   = cur_idx + IDX_ONE;
            state_nxt = LOAD;
          end
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
